// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the BittyPro fetch/issue sequencer.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_RSP  = 3'd2,
    S_EXEC      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [15:0] HALT_INST_DEF   = 16'hFFFF;
  localparam int          TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: valid/ready fetch of one instruction, start pulse, wait for done; >=4 cycles per instruction.
// Request held until ready; responses and done are sampled only in their wait states. FETCH_WDOG_EN adds a watchdog.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                INST_W      = 16,
  parameter logic [INST_W-1:0] HALT_INST   = INST_W'(HALT_INST_DEF),
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  output logic [INST_W-1:0] inst,
  output logic              exec_start,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              wdog_err
);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INST_W-1:0]   r_inst;
  logic                w_rsp_take;
  logic                w_done_take;
  logic                w_wdog_fire;

  assign w_rsp_take  = (r_state == S_WAIT_RSP)  && mem_rsp_valid;
  assign w_done_take = (r_state == S_WAIT_DONE) && exec_done;

`ifdef FETCH_WDOG_EN
  localparam int WDOG_W = 8;

  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;
  logic              w_waiting;

  assign w_waiting   = (r_state == S_WAIT_RSP) || (r_state == S_WAIT_DONE);
  // A real response/done in the final cycle wins over the timeout.
  assign w_wdog_fire = w_waiting && !(w_rsp_take || w_done_take) &&
                       (r_wdog_cnt == WDOG_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      r_wdog_cnt <= w_waiting ? r_wdog_cnt + 1'b1 : '0;
      if (w_wdog_fire) r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYC != 0);
  assign w_wdog_fire  = 1'b0;
  assign wdog_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (run) w_next_state = S_REQ;
      S_REQ:       if (mem_req_ready) w_next_state = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (mem_rsp_valid) w_next_state = (mem_rsp_data == HALT_INST) ? S_HALT : S_EXEC;
        else if (w_wdog_fire) w_next_state = S_HALT;
      end
      S_EXEC:      w_next_state = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // run is only consulted here, so a drop never aborts an instruction.
        if (exec_done) w_next_state = run ? S_REQ : S_IDLE;
        else if (w_wdog_fire) w_next_state = S_HALT;
      end
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    exec_start    = 1'b0;
    busy          = 1'b0;
    halted        = 1'b0;
    case (r_state)
      S_REQ: begin
        mem_req_valid = 1'b1;
        busy          = 1'b1;
      end
      S_WAIT_RSP, S_WAIT_DONE: busy = 1'b1;
      S_EXEC: begin
        exec_start = 1'b1;
        busy       = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= '0;
      r_inst <= '0;
    end else begin
      if (w_rsp_take)  r_inst <= mem_rsp_data;
      if (w_done_take) r_pc   <= r_pc + 1'b1;
    end
  end

  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign inst     = r_inst;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: randomized memory/controlunit models plus a PC/instruction-stream reference model.
module tb_fetch_sequencer;

  localparam int          AW   = 8;
  localparam int          IW   = 16;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [IW-1:0] mem_rsp_data = '0;
  logic [IW-1:0] inst;
  logic          exec_start;
  logic          exec_done = 1'b0;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          wdog_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .INST_W(IW), .HALT_INST(HALT), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst(inst), .exec_start(exec_start), .exec_done(exec_done),
    .pc(pc), .busy(busy), .halted(halted), .wdog_err(wdog_err)
  );

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] mem [256];

  // Environment knobs
  int p_ready = 100, rsp_dmin = 1, rsp_dmax = 1, done_dmin = 3, done_dmax = 3, stall_left = 0;
  bit spur_rsp = 0, early_done = 0, no_done = 0, chk_en = 1, in_reset = 0;

  // Memory / controlunit responder state
  bit            m_pend = 0, m_stale = 0;
  int            m_cnt = 0;
  logic [AW-1:0] m_addr = '0;
  bit            d_pend = 0;
  int            d_cnt = 0;

  // Reference model: architectural view of the fetch stream
  logic [AW-1:0] exp_pc = '0;
  logic [IW-1:0] exp_inst = '0;
  bit            exp_halted = 0, exp_idle = 1, exp_start_due = 0;
  int            cyc = 0, n_done = 0, n_start = 0;
  bit            saw_wrap = 0;

  task automatic cycle();
    bit            rsp_now = 0, done_now = 0, rv = 0, rdy = 0, dn = 0;
    logic [IW-1:0] rdat;
    if (chk_en && !in_reset) begin
      checks++;
      if (exec_start !== exp_start_due) begin errors++; $display("FAIL exec_start cyc=%0d got=%b exp=%b", cyc, exec_start, exp_start_due); end
      checks++;
      if (pc !== exp_pc) begin errors++; $display("FAIL pc cyc=%0d got=%0d exp=%0d", cyc, pc, exp_pc); end
      checks++;
      if (inst !== exp_inst) begin errors++; $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst, exp_inst); end
      checks++;
      if (halted !== exp_halted) begin errors++; $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, exp_halted); end
      checks++;
      if (busy !== (!exp_halted && !exp_idle)) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !exp_halted && !exp_idle); end
      checks++;
      if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_err cyc=%0d got=%b exp=0", cyc, wdog_err); end
      if (mem_req_valid && mem_addr !== exp_pc) begin
        checks++; errors++; $display("FAIL req_addr cyc=%0d got=%0d exp=%0d", cyc, mem_addr, exp_pc);
      end
      if (exp_idle || exp_halted) begin
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL req_when_stopped cyc=%0d got=%b exp=0", cyc, mem_req_valid); end
      end
    end
    if (exec_start) n_start++;

    rdat = {1'b0, 15'($urandom)};
    if (m_pend) begin
      if (m_cnt == 0) begin
        rv = 1; rdat = mem[m_addr]; rsp_now = !m_stale; m_pend = 0; m_stale = 0;
      end else m_cnt--;
    end else if (spur_rsp && !in_reset && $urandom_range(0, 2) == 0) rv = 1;
    mem_rsp_valid = rv;
    mem_rsp_data  = rdat;

    if (!in_reset && mem_req_valid) begin
      if (stall_left > 0) stall_left--;
      else rdy = ($urandom_range(1, 100) <= p_ready);
    end
    if (rdy) begin
      m_pend = 1; m_stale = 0; m_addr = mem_addr;
      m_cnt  = $urandom_range(rsp_dmin, rsp_dmax) - 1;
      if (mem_addr == 0 && n_done >= 256) saw_wrap = 1;
    end
    mem_req_ready = rdy;

    if (!in_reset) begin
      if (d_pend) begin
        d_cnt--;
        if (d_cnt == 0) begin dn = 1; done_now = 1; d_pend = 0; end
      end
      if (exec_start) begin
        if (!no_done) begin d_pend = 1; d_cnt = $urandom_range(done_dmin, done_dmax); end
        if (early_done) dn = 1;
      end
    end
    exec_done = dn;

    @(posedge clk);
    #1;
    cyc++;

    if (!in_reset) begin
      exp_start_due = 0;
      if (rsp_now) begin
        exp_inst = rdat;
        if (rdat == HALT) exp_halted = 1;
        else exp_start_due = 1;
      end
      if (done_now) begin
        exp_pc = exp_pc + 1'b1;
        n_done++;
        if (!run) exp_idle = 1;
      end else if (exp_idle && run) exp_idle = 0;
    end
  endtask

  task automatic do_reset(input bit keep_pend);
    in_reset = 1; reset = 1;
    cycle(); cycle();
    reset = 0; in_reset = 0; d_pend = 0;
    if (keep_pend) m_stale = 1; else m_pend = 0;
    exp_pc = '0; exp_inst = '0; exp_halted = 0; exp_idle = 1; exp_start_due = 0; n_done = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, 15'($urandom)};
  endtask

  task automatic test_reset();
    run = 0;
    do_reset(0);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (exec_start !== 1'b0) begin errors++; $display("FAIL rst_exec_start got=%b exp=0", exec_start); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL rst_wdog got=%b exp=0", wdog_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (pc !== '0) begin errors++; $display("FAIL rst_pc got=%0d exp=0", pc); end
    checks++; if (inst !== '0) begin errors++; $display("FAIL rst_inst got=%h exp=0", inst); end
    repeat (3) cycle();
  endtask

  task automatic test_basic();
    int c0, s0;
    fill_mem(); mem[0] = 16'h1234;
    p_ready = 100; rsp_dmin = 1; rsp_dmax = 1; done_dmin = 3; done_dmax = 3;
    do_reset(0);
    run = 1;
    for (int i = 0; i < 10 && !mem_req_valid; i++) cycle();
    checks++;
    if (!mem_req_valid) begin errors++; $display("FAIL basic_req_timeout got=0 exp=1"); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL basic_addr got=%0d exp=0", mem_addr); end
    c0 = cyc; s0 = n_start;
    repeat (6) cycle();
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL basic_starts got=%0d exp=1", n_start - s0); end
    checks++; if (!(mem_req_valid === 1'b1 && cyc == c0 + 6)) begin errors++; $display("FAIL basic_next_req got=%b exp=1", mem_req_valid); end
    checks++; if (pc !== 8'd1) begin errors++; $display("FAIL basic_pc got=%0d exp=1", pc); end
    checks++; if (inst !== 16'h1234) begin errors++; $display("FAIL basic_inst got=%h exp=1234", inst); end
    run = 0;
    repeat (12) cycle();
  endtask

  task automatic test_stall();
    int vcnt = 0, w = 0;
    fill_mem();
    p_ready = 100; rsp_dmin = 3; rsp_dmax = 3; spur_rsp = 1; early_done = 1;
    do_reset(0);
    stall_left = 4; run = 1;
    cycle();
    for (int i = 0; i < 20 && mem_req_valid; i++) begin vcnt++; cycle(); end
    checks++; if (vcnt != 5) begin errors++; $display("FAIL stall_valid_cycles got=%0d exp=5", vcnt); end
    while (!exec_start && w < 20) begin
      checks++; if (inst !== '0) begin errors++; $display("FAIL stall_early_inst got=%h exp=0", inst); end
      cycle(); w++;
    end
    checks++; if (w != 3) begin errors++; $display("FAIL stall_rsp_wait got=%0d exp=3", w); end
    checks++; if (inst !== mem[0]) begin errors++; $display("FAIL stall_inst got=%h exp=%h", inst, mem[0]); end
    run = 0;
    repeat (12) cycle();
    spur_rsp = 0; early_done = 0; rsp_dmin = 1; rsp_dmax = 1;
  endtask

  task automatic test_halt();
    int s0;
    fill_mem(); mem[2] = HALT;
    p_ready = 70; rsp_dmin = 1; rsp_dmax = 3; done_dmin = 1; done_dmax = 4;
    do_reset(0);
    s0 = n_start; run = 1;
    for (int i = 0; i < 200 && !halted; i++) cycle();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_reached got=%b exp=1", halted); end
    checks++; if (pc !== 8'd2) begin errors++; $display("FAIL halt_pc got=%0d exp=2", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_busy got=%b exp=0", busy); end
    checks++; if (n_start - s0 != 2) begin errors++; $display("FAIL halt_starts got=%0d exp=2", n_start - s0); end
    for (int i = 0; i < 12; i++) begin run = i[0]; cycle(); end
    checks++; if (halted !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky got=%b/%b exp=1/0", halted, mem_req_valid); end
    checks++; if (n_start - s0 != 2) begin errors++; $display("FAIL halt_no_start got=%0d exp=2", n_start - s0); end
  endtask

  task automatic test_run_drop();
    int d0, i;
    fill_mem();
    p_ready = 100; rsp_dmin = 1; rsp_dmax = 1; done_dmin = 3; done_dmax = 3;
    do_reset(0);
    run = 1;
    for (i = 0; i < 20 && !exec_start; i++) cycle();
    d0 = n_done;
    cycle();
    run = 0;
    for (i = 0; i < 20 && n_done == d0; i++) cycle();
    checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL drop_completed got=%0d exp=%0d", n_done, d0 + 1); end
    checks++; if (pc !== 8'd1) begin errors++; $display("FAIL drop_pc got=%0d exp=1", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
    for (i = 0; i < 5; i++) begin
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL drop_no_req got=%b exp=0", mem_req_valid); end
      cycle();
    end
    run = 1;
    cycle();
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 8'd1) begin errors++; $display("FAIL drop_resume got=%b@%0d exp=1@1", mem_req_valid, mem_addr); end
    run = 0;
    repeat (12) cycle();
  endtask

  task automatic test_random_wrap();
    int i;
    fill_mem();
    p_ready = 60; rsp_dmin = 1; rsp_dmax = 4; done_dmin = 1; done_dmax = 5; spur_rsp = 1;
    do_reset(0);
    saw_wrap = 0; run = 1;
    for (i = 0; i < 20000 && n_done < 260; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      early_done = ($urandom_range(0, 3) == 0);
      cycle();
    end
    checks++; if (n_done < 260) begin errors++; $display("FAIL rand_progress got=%0d exp>=260", n_done); end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL rand_wrap_fetch got=%b exp=1", saw_wrap); end
    spur_rsp = 0; early_done = 0; run = 0;
    repeat (12) cycle();
  endtask

  task automatic test_reset_mid();
    int i;
    fill_mem();
    p_ready = 100; rsp_dmin = 6; rsp_dmax = 6; done_dmin = 3; done_dmax = 3;
    do_reset(0);
    run = 1;
    for (i = 0; i < 10 && !m_pend; i++) cycle();
    run = 0;
    do_reset(1);
    for (i = 0; i < 10 && m_pend; i++) cycle();
    repeat (2) cycle();
    checks++; if (inst !== '0 || busy !== 1'b0) begin errors++; $display("FAIL stale_rsp got=%h/%b exp=0/0", inst, busy); end
    rsp_dmin = 1; rsp_dmax = 1; run = 1;
    for (i = 0; i < 20 && !exec_start; i++) cycle();
    cycle();
    run = 0;
    do_reset(0);
    checks++; if (pc !== '0 || inst !== '0 || exec_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_exec got=%0d/%h/%b/%b exp=0/0/0/0", pc, inst, exec_start, busy);
    end
    repeat (6) cycle();
  endtask

  task automatic test_watchdog();
    int c0, i;
    fill_mem();
    p_ready = 100; rsp_dmin = 1; rsp_dmax = 1;
    do_reset(0);
    no_done = 1; run = 1;
    for (i = 0; i < 20 && !exec_start; i++) cycle();
    c0 = cyc; chk_en = 0;
`ifdef FETCH_WDOG_EN
    for (i = 0; i < 40 && !halted; i++) cycle();
    checks++; if (cyc - c0 != 17) begin errors++; $display("FAIL wdog_timing got=%0d exp=17", cyc - c0); end
    checks++; if (halted !== 1'b1 || wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_flags got=%b/%b exp=1/1", halted, wdog_err); end
    run = 0;
    do_reset(0);
    checks++; if (halted !== 1'b0 || wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_reset got=%b/%b exp=0/0", halted, wdog_err); end
`else
    for (i = 0; i < 40; i++) cycle();
    checks++; if (halted !== 1'b0 || busy !== 1'b1 || wdog_err !== 1'b0) begin
      errors++; $display("FAIL nowdog_wait got=%b/%b/%b exp=0/1/0", halted, busy, wdog_err);
    end
    checks++; if (cyc - c0 != 40) begin errors++; $display("FAIL nowdog_cycles got=%0d exp=40", cyc - c0); end
    run = 0;
    do_reset(0);
`endif
    no_done = 0; chk_en = 1;
    repeat (3) cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_halt();
    test_run_drop();
    test_random_wrap();
    test_reset_mid();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
